// File: rtl/wdt_apb_regs.sv
// APB-lite register front end for the 32-bit watchdog counter.
// Decodes bus writes into feed/update pulses, mode and start value.
// Captures watchdog interrupt/timeout edges into sticky status bits.
module wdt_apb_regs #(
  parameter logic [31:0] FEED_KEY     = 32'h5A5A_A5A5,
  parameter logic [31:0] UNLOCK_KEY   = 32'h1ACC_E551,
  parameter logic [31:0] DEFAULT_LOAD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [4:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        flag,
  output logic [1:0]  mode,
  output logic        update,
  output logic [31:0] start_value,
  input  logic        wd_intr,
  input  logic        wd_timeout,
  output logic        irq,
  output logic        rst_req
);

  // Word offsets (paddr[4:2]).
  localparam logic [2:0] REG_LOAD   = 3'd0;
  localparam logic [2:0] REG_CTRL   = 3'd1;
  localparam logic [2:0] REG_FEED   = 3'd2;
  localparam logic [2:0] REG_LOCK   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;
  localparam logic [2:0] REG_INTEN  = 3'd5;

  logic [31:0] load_q,       load_d;
  logic [1:0]  mode_q,       mode_d;
  logic        locked_q,     locked_d;
  logic [2:0]  status_q,     status_d;
  logic        inten_q,      inten_d;
  logic        flag_q,       flag_d;
  logic        update_q,     update_d;
  logic        intr_prev_q,  intr_prev_d;
  logic        intr_rise_q,  intr_rise_d;
  logic        tmo_prev_q,   tmo_prev_d;
  logic        tmo_rise_q,   tmo_rise_d;

  logic [2:0] word;
  logic       access;
  logic       addr_ok;
  logic       wr_en;
  logic       cfg_blocked;
  logic       unused_addr_bits;

  assign word             = paddr[4:2];
  assign unused_addr_bits = ^paddr[1:0];
  assign access           = psel & penable;
  assign addr_ok          = (word <= REG_INTEN);
  assign wr_en            = access & pwrite & addr_ok;
  assign cfg_blocked      = locked_q & ((word == REG_LOAD) | (word == REG_CTRL));

  // Bus handshake and direct register-driven outputs.
  always_comb begin
    pready      = access;
    pslverr     = access & (~addr_ok | (pwrite & cfg_blocked));
    flag        = flag_q;
    update      = update_q;
    mode        = mode_q;
    start_value = load_q;
    irq         = status_q[0] & inten_q;
    rst_req     = status_q[1];
  end

  // Read data mux; zero outside a valid read access.
  always_comb begin
    prdata = '0;
    if (access && !pwrite && addr_ok) begin
      case (word)
        REG_LOAD:   prdata = load_q;
        REG_CTRL:   prdata = {30'd0, mode_q};
        REG_LOCK:   prdata = {31'd0, locked_q};
        REG_STATUS: prdata = {29'd0, status_q};
        REG_INTEN:  prdata = {31'd0, inten_q};
        default:    prdata = '0;
      endcase
    end
  end

  // Next-state for registers, pulses, edge detectors and sticky status.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    load_d      = load_q;
    mode_d      = mode_q;
    locked_d    = locked_q;
    inten_d     = inten_q;
    status_d    = status_q;
    flag_d      = 1'b0;
    update_d    = 1'b0;
    intr_prev_d = wd_intr;
    tmo_prev_d  = wd_timeout;
    intr_rise_d = wd_intr & ~intr_prev_q;
    tmo_rise_d  = wd_timeout & ~tmo_prev_q;

    if (wr_en) begin
      case (word)
        REG_LOAD: if (!locked_q) begin
          load_d   = pwdata;
          update_d = 1'b1;
        end
        REG_CTRL: if (!locked_q) mode_d = pwdata[1:0];
        REG_FEED: begin
          if (pwdata == FEED_KEY) flag_d = 1'b1;
          else                    status_d[2] = 1'b1;
        end
        REG_LOCK:   locked_d = (pwdata != UNLOCK_KEY);
        REG_STATUS: status_d = status_q & ~pwdata[2:0];
        REG_INTEN:  inten_d  = pwdata[0];
        default: ;
      endcase
    end

    // Hardware set is applied after write-1-to-clear so a coincident set wins.
    if (intr_rise_q) status_d[0] = 1'b1;
    if (tmo_rise_q)  status_d[1] = 1'b1;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      load_q      <= DEFAULT_LOAD;
      mode_q      <= 2'b00;
      locked_q    <= 1'b0;
      status_q    <= 3'b000;
      inten_q     <= 1'b0;
      flag_q      <= 1'b0;
      update_q    <= 1'b0;
      intr_prev_q <= 1'b0;
      intr_rise_q <= 1'b0;
      tmo_prev_q  <= 1'b0;
      tmo_rise_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
      load_q      <= load_d;
      mode_q      <= mode_d;
      locked_q    <= locked_d;
      status_q    <= status_d;
      inten_q     <= inten_d;
      flag_q      <= flag_d;
      update_q    <= update_d;
      intr_prev_q <= intr_prev_d;
      intr_rise_q <= intr_rise_d;
      tmo_prev_q  <= tmo_prev_d;
      tmo_rise_q  <= tmo_rise_d;
    end
  end

endmodule
